// File: rtl/fade_engine.sv
// fade_engine: multi-channel autonomous INC/ON_HOLD/DEC/OFF_HOLD fade sequencer with a shared tick prescaler.
// Define FADE_ENGINE_PWM_EN to build the shared PWM counter and per-channel comparators; otherwise pwm_out is 0.
module fade_engine #(
    parameter int                  NUM_CH         = 3,
    parameter int                  TICK_CYCLES    = 12000,
    parameter int                  PWM_INTERVAL   = 1200,
    parameter int                  RAMP_STEPS     = 200,
    parameter int                  HOLD_ON_STEPS  = 400,
    parameter int                  HOLD_OFF_STEPS = 400,
    parameter logic [2*NUM_CH-1:0] START_STATE    = {2'b11, 2'b00, 2'b10}
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      enable,
    input  logic                                      restart,
    output logic                                      tick,
    output logic [2*NUM_CH-1:0]                       state,
    output logic [NUM_CH*$clog2(PWM_INTERVAL+1)-1:0]  duty,
    output logic [NUM_CH-1:0]                         pwm_out
);

    localparam int W       = $clog2(PWM_INTERVAL + 1);
    localparam int MAX_LEN = (RAMP_STEPS > HOLD_ON_STEPS)
                           ? ((RAMP_STEPS > HOLD_OFF_STEPS) ? RAMP_STEPS : HOLD_OFF_STEPS)
                           : ((HOLD_ON_STEPS > HOLD_OFF_STEPS) ? HOLD_ON_STEPS : HOLD_OFF_STEPS);
    localparam int SW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PW      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [W:0] STEP = (W+1)'(PWM_INTERVAL / RAMP_STEPS);
    localparam logic [W:0] TOP  = (W+1)'(PWM_INTERVAL);

    typedef enum logic [1:0] {
        INC      = 2'b00,
        DEC      = 2'b01,
        ON_HOLD  = 2'b10,
        OFF_HOLD = 2'b11
    } fade_state_e;

    logic [PW-1:0] presc;
    fade_state_e   st_q   [NUM_CH];
    fade_state_e   st_d   [NUM_CH];
    logic [SW-1:0] step_q [NUM_CH];
    logic [SW-1:0] step_d [NUM_CH];
    logic [W-1:0]  duty_q [NUM_CH];
    logic [W-1:0]  duty_d [NUM_CH];

    function automatic fade_state_e succ(input fade_state_e s);
        case (s)
            INC:     return ON_HOLD;
            ON_HOLD: return DEC;
            DEC:     return OFF_HOLD;
            default: return INC;
        endcase
    endfunction

    function automatic logic [SW-1:0] last_step(input fade_state_e s);
        case (s)
            INC, DEC: return SW'(RAMP_STEPS - 1);
            ON_HOLD:  return SW'(HOLD_ON_STEPS - 1);
            default:  return SW'(HOLD_OFF_STEPS - 1);
        endcase
    endfunction

    function automatic logic [W-1:0] entry_duty(input fade_state_e s);
        return (s == ON_HOLD || s == DEC) ? TOP[W-1:0] : '0;
    endfunction

    // Saturation is evaluated one bit wider than duty so the sum can never wrap.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] d);
        logic [W:0] sum;
        sum = {1'b0, d} + STEP;
        return (sum > TOP) ? TOP[W-1:0] : sum[W-1:0];
    endfunction

    function automatic logic [W-1:0] sat_dec(input logic [W-1:0] d);
        return ({1'b0, d} < STEP) ? '0 : d - STEP[W-1:0];
    endfunction

    function automatic fade_state_e start_of(input int c);
        return fade_state_e'(START_STATE[2*c +: 2]);
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            st_d[c]   = st_q[c];
            step_d[c] = step_q[c];
            duty_d[c] = duty_q[c];
            if (tick && enable) begin
                if (step_q[c] == last_step(st_q[c])) begin
                    step_d[c] = '0;
                    st_d[c]   = succ(st_q[c]);
                    duty_d[c] = entry_duty(succ(st_q[c]));
                end else begin
                    step_d[c] = step_q[c] + SW'(1);
                    if (st_q[c] == INC)
                        duty_d[c] = sat_inc(duty_q[c]);
                    else if (st_q[c] == DEC)
                        duty_d[c] = sat_dec(duty_q[c]);
                end
            end
        end
    end

    // restart is checked before the tick path so a coincident tick is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            tick  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]   <= start_of(c);
                step_q[c] <= '0;
                duty_q[c] <= entry_duty(start_of(c));
            end
        end else if (restart) begin
            presc <= '0;
            tick  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]   <= start_of(c);
                step_q[c] <= '0;
                duty_q[c] <= entry_duty(start_of(c));
            end
        end else begin
            tick <= 1'b0;
            if (enable) begin
                if (presc == PW'(TICK_CYCLES - 1)) begin
                    presc <= '0;
                    tick  <= 1'b1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]   <= st_d[c];
                step_q[c] <= step_d[c];
                duty_q[c] <= duty_d[c];
            end
        end
    end

    always_comb begin
        state = '0;
        duty  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state[2*c +: 2] = st_q[c];
            duty[W*c +: W]  = duty_q[c];
        end
    end

`ifdef FADE_ENGINE_PWM_EN
    localparam int CW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    logic [CW-1:0] pwm_cnt;

    // The PWM counter free-runs regardless of enable so frozen duty keeps its waveform.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            pwm_out <= '0;
        end else if (restart) begin
            pwm_cnt <= '0;
            pwm_out <= '0;
        end else begin
            pwm_cnt <= (pwm_cnt == CW'(PWM_INTERVAL - 1)) ? '0 : pwm_cnt + CW'(1);
            for (int c = 0; c < NUM_CH; c++)
                pwm_out[c] <= (W'(pwm_cnt) < duty_q[c]);
        end
    end
`else
    assign pwm_out = '0;
`endif

endmodule

// File: tb/tb_fade_engine.sv
// tb_fade_engine: two fade_engine instances (PWM_INTERVAL 12 and 13) checked every cycle against a position-based model.
// Model derives state/duty from each channel's position within the full fade period.
module tb_fade_engine;

    localparam int NCH  = 2;
    localparam int TCK  = 4;
    localparam int R    = 4;
    localparam int HON  = 2;
    localparam int HOFF = 2;
    localparam int P    = 2*R + HON + HOFF;
    localparam int PI_A = 12;
    localparam int PI_B = 13;
    localparam int WA   = $clog2(PI_A + 1);
    localparam int WB   = $clog2(PI_B + 1);
    localparam logic [2*NCH-1:0] START = {2'b11, 2'b00};
    localparam int START_POS [NCH] = '{0, 2*R + HON};
`ifdef FADE_ENGINE_PWM_EN
    localparam bit PWM_ON = 1'b1;
`else
    localparam bit PWM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;
    logic restart = 1'b0;

    logic              tick_a, tick_b;
    logic [2*NCH-1:0]  state_a, state_b;
    logic [NCH*WA-1:0] duty_a;
    logic [NCH*WB-1:0] duty_b;
    logic [NCH-1:0]    pwm_a, pwm_b;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fade_engine #(
        .NUM_CH(NCH), .TICK_CYCLES(TCK), .PWM_INTERVAL(PI_A), .RAMP_STEPS(R),
        .HOLD_ON_STEPS(HON), .HOLD_OFF_STEPS(HOFF), .START_STATE(START)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
        .tick(tick_a), .state(state_a), .duty(duty_a), .pwm_out(pwm_a)
    );

    fade_engine #(
        .NUM_CH(NCH), .TICK_CYCLES(TCK), .PWM_INTERVAL(PI_B), .RAMP_STEPS(R),
        .HOLD_ON_STEPS(HON), .HOLD_OFF_STEPS(HOFF), .START_STATE(START)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
        .tick(tick_b), .state(state_b), .duty(duty_b), .pwm_out(pwm_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int exp_duty(input int pos, input int pi);
        int stp;
        stp = pi / R;
        if (pos < R)             return (pos*stp > pi) ? pi : pos*stp;
        if (pos < R + HON)       return pi;
        if (pos < 2*R + HON)     return (pi - (pos-R-HON)*stp < 0) ? 0 : pi - (pos-R-HON)*stp;
        return 0;
    endfunction

    function automatic int exp_state(input int pos);
        if (pos < R)         return 0;
        if (pos < R + HON)   return 2;
        if (pos < 2*R + HON) return 1;
        return 3;
    endfunction

    bit             m_tick;
    int             m_en;
    int             m_pos [NCH];
    int             m_pcnt [2];
    bit [NCH-1:0]   m_pwm [2];
    int             m_pi [2] = '{PI_A, PI_B};

    task automatic model_reset();
        m_tick = 1'b0;
        m_en   = 0;
        for (int c = 0; c < NCH; c++) m_pos[c] = START_POS[c];
        for (int i = 0; i < 2; i++) begin
            m_pcnt[i] = 0;
            m_pwm[i]  = '0;
        end
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || restart) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < NCH; c++)
                    m_pwm[i][c] = PWM_ON && (m_pcnt[i] < exp_duty(m_pos[c], m_pi[i]));
                m_pcnt[i] = (m_pcnt[i] + 1) % m_pi[i];
            end
            if (m_tick && enable)
                for (int c = 0; c < NCH; c++) m_pos[c] = (m_pos[c] + 1) % P;
            m_tick = enable && (((m_en + 1) % TCK) == 0);
            if (enable) m_en++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("tick_a", tick_a, m_tick);
        check("tick_b", tick_b, m_tick);
        for (int c = 0; c < NCH; c++) begin
            check("state_a", state_a[2*c +: 2], exp_state(m_pos[c]));
            check("state_b", state_b[2*c +: 2], exp_state(m_pos[c]));
            check("duty_a", duty_a[WA*c +: WA], exp_duty(m_pos[c], PI_A));
            check("duty_b", duty_b[WB*c +: WB], exp_duty(m_pos[c], PI_B));
        end
        check("pwm_a", pwm_a, m_pwm[0]);
        check("pwm_b", pwm_b, m_pwm[1]);
    end

    // ---------------- stimulus and literal pins ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        check("lit_tick_e3", tick_a, 0);
        cycles(1);
        check("lit_tick_e4", tick_a, 1);
        cycles(1);
        check("lit_duty_a0_e5", duty_a[3:0], 3);
        check("lit_state_a0_e5", state_a[1:0], 0);
        cycles(12);
        check("lit_duty_a0_e17", duty_a[3:0], 12);
        check("lit_state_a0_e17", state_a[1:0], 2);
        check("lit_duty_a1_e17", duty_a[7:4], 6);
        check("lit_duty_b0_e17", duty_b[3:0], 13);
        cycles(12);
        check("lit_duty_a0_e29", duty_a[3:0], 9);
        check("lit_state_a0_e29", state_a[1:0], 1);
        check("lit_duty_b0_e29", duty_b[3:0], 10);
        cycles(12);
        check("lit_duty_a0_e41", duty_a[3:0], 0);
        check("lit_state_a0_e41", state_a[1:0], 3);
        cycles(12);
        check("lit_duty_a0_e53", duty_a[3:0], 3);

        // asynchronous reset mid-run
        #2 rst_n = 1'b0;
        cycles(1);
        check("lit_rst_duty", duty_a, 0);
        check("lit_rst_state", state_a, 4'b1100);
        check("lit_rst_tick", tick_a, 0);
        check("lit_rst_pwm", pwm_a, 0);
        cycles(2);
        rst_n = 1'b1;

        // restart coinciding with tick while ch0 sits at duty 9
        cycles(13);
        check("lit_pre_restart_duty", duty_a[3:0], 9);
        cycles(3);
        check("lit_pre_restart_tick", tick_a, 1);
        restart = 1'b1;
        cycles(1);
        restart = 1'b0;
        check("lit_restart_duty", duty_a, 0);
        check("lit_restart_state", state_a, 4'b1100);
        check("lit_restart_tick", tick_a, 0);
        cycles(4);
        check("lit_restart_first_tick", tick_a, 1);

        // freeze mid-INC
        cycles(6);
        check("lit_pre_freeze_duty", duty_a[3:0], 6);
        enable = 1'b0;
        cycles(10);
        check("lit_frozen_duty", duty_a[3:0], 6);
        check("lit_frozen_tick", tick_a, 0);
        enable = 1'b1;

        // randomized phase
        for (int k = 0; k < 3000; k++) begin
            enable  = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                cycles(1);
                rst_n = 1'b1;
            end else begin
                cycles(1);
            end
        end
        enable  = 1'b1;
        restart = 1'b0;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
